mc_ctrl: RTL and testbench
==========================

Name: mc_ctrl

Overview:
- Multi-cycle control unit, successor to the single-cycle Ctrl decoder; sequences each instruction through FETCH/DECODE/EXEC/MEM/WB over shared datapath units.
- Adds req/ack handshakes to instruction and data memory, a parametrised wait watchdog, illegal-opcode detection and a retired-instruction counter.
- Sits between the instruction register (which supplies op/funct) and the PC, GRF, ALU, Ext, DM and mux selects of the multi-cycle datapath.

Parameters:
- WAIT_MAX, 15: maximum extra cycles a request may wait for ack before the watchdog fires; 0 disables the watchdog.
- CNT_W, 32: width of the retired-instruction counter.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- op  in  6  opcode from the IR; valid from DECODE onward.
- funct  in  6  funct field from the IR.
- zero  in  1  ALU equality flag, sampled in EXEC.
- imem_ack  in  1  instruction memory ack.
- dmem_ack  in  1  data memory ack.
- imem_req  out  1  instruction fetch request.
- dmem_req  out  1  data access request.
- mem_write  out  1  DM write enable, qualifies dmem_req.
- ir_write  out  1  IR load strobe.
- pc_write  out  1  PC load strobe.
- reg_write  out  1  GRF write strobe.
- npc_src  out  2  next-PC select: 0 PC+4, 1 branch, 2 jump, 3 rs.
- reg_src  out  2  GRF write-data select: 0 ALU, 1 DM, 2 Ext, 3 PC+4.
- alu_op  out  3  ALU operation: 0 add, 1 sub, 2 or.
- alu_src  out  1  ALU B operand: 0 rt, 1 Ext.
- ext_op  out  2  extender mode: 0 zero, 1 sign, 2 lui.
- reg_dst  out  2  destination register: 0 rt, 1 rd, 2 $31.
- illegal  out  1  one-cycle pulse in EXEC for an unrecognised instruction.
- bus_err  out  1  sticky watchdog flag.
- retired  out  CNT_W  count of retired instructions.
- state  out  3  current state: FETCH 0, DECODE 1, EXEC 2, MEM 3, WB 4, HALT 7.

Behaviour:
- Reset (reset==0, asynchronous) forces: state FETCH, retired 0, bus_err 0, wait counter 0, all strobes and reqs 0.
- While reset is low, strobes and reqs are gated off. Releasing reset lets FETCH drive imem_req on the next cycle.
- Supported instructions:
  - R-type (op 000000): addu funct 100001, subu 100011, jr 001000.
  - ori 001101, lui 001111, lw 100011, sw 101011, beq 000100, j 000010, jal 000011.
  - Anything else is illegal and executes as a nop.
- Select outputs (npc_src, reg_src, alu_op, alu_src, ext_op, reg_dst) are a combinational decode of op/funct in every state. Strobes are Moore outputs of the state.
- FETCH:
  - imem_req=1 until imem_ack is sampled high.
  - On the ack cycle: ir_write=1, next state DECODE.
- DECODE: no strobes; always goes to EXEC.
- EXEC:
  - beq: pc_write=1, npc_src=1 if zero else 0, then FETCH.
  - j: pc_write=1 with npc_src=2, then FETCH.
  - jr: pc_write=1 with npc_src=3, then FETCH.
  - illegal: illegal=1, pc_write=1 with npc_src=0, then FETCH.
  - lw/sw: go to MEM.
  - Others: go to WB.
- MEM:
  - dmem_req=1 and mem_write=(op==sw), held until dmem_ack.
  - On ack, sw: pc_write=1 (npc_src 0), then FETCH.
  - On ack, lw: go to WB.
- WB:
  - reg_write=1 and pc_write=1 in the same cycle, then FETCH.
  - jal: reg_dst=2, reg_src=3, npc_src=2.
  - PC+4 is computed from the unchanged PC, because the PC updates only at retirement.
- Exactly one pc_write pulse per instruction. retired increments on each pc_write and wraps modulo 2^CNT_W.
- Watchdog:
  - The wait counter clears on entry to FETCH or MEM.
  - It increments each cycle a req is high without ack.
  - If WAIT_MAX>0, counter==WAIT_MAX and no ack: next state HALT, bus_err set.
  - A request may therefore wait at most WAIT_MAX+1 cycles.
  - Ack arriving in the same cycle the counter reaches WAIT_MAX wins and the access completes.
- HALT: all strobes and reqs 0, retired frozen; leaves only via reset.
- Reset asserted mid-instruction aborts it: no further strobes, no retirement counted.
- Latency with zero-wait memories:
  - beq/j/jr: 3 cycles.
  - R-type/ori/lui/jal/sw: 4 cycles.
  - lw: 5 cycles.

Test Plan:
- addu (op 0, funct 100001), imem_ack tied high -> states 0,1,2,4. WB shows reg_write=1, pc_write=1, reg_dst=1, reg_src=0, alu_op=0. retired 0->1.
- beq with zero=1, then beq with zero=0 -> each retires in 3 cycles. EXEC pc_write with npc_src 1 then 0. reg_write never asserted.
- lw with dmem_ack delayed 3 cycles -> dmem_req high 4 cycles, mem_write=0. WB reg_src=1, alu_src=1, ext_op=1. Total 8 cycles.
- jal -> WB reg_dst=2, reg_src=3, npc_src=2, reg_write=1, pc_write=1 in one cycle.
- op 111111 -> illegal pulse in EXEC, pc_write with npc_src=0, no reg_write. retired increments.
- WAIT_MAX=3, imem_ack held low -> imem_req high exactly 4 cycles, then state 7, bus_err=1, retired frozen. reset low then high -> state 0, bus_err 0, retired 0.

Source files
------------

// File: rtl/mc_ctrl_if.sv
// Control-unit bus: IR fields, memory handshakes, datapath strobes and selects.
// master = the control unit, slave = datapath / memories side.
interface mc_ctrl_if #(
  parameter int unsigned CNT_W = 32
) ();
  logic [5:0]       op;
  logic [5:0]       funct;
  logic             zero;
  logic             imem_ack;
  logic             dmem_ack;
  logic             imem_req;
  logic             dmem_req;
  logic             mem_write;
  logic             ir_write;
  logic             pc_write;
  logic             reg_write;
  logic [1:0]       npc_src;
  logic [1:0]       reg_src;
  logic [2:0]       alu_op;
  logic             alu_src;
  logic [1:0]       ext_op;
  logic [1:0]       reg_dst;
  logic             illegal;
  logic             bus_err;
  logic [CNT_W-1:0] retired;
  logic [2:0]       state;

  modport master (
    input  op, funct, zero, imem_ack, dmem_ack,
    output imem_req, dmem_req, mem_write, ir_write, pc_write, reg_write,
    output npc_src, reg_src, alu_op, alu_src, ext_op, reg_dst,
    output illegal, bus_err, retired, state
  );

  modport slave (
    output op, funct, zero, imem_ack, dmem_ack,
    input  imem_req, dmem_req, mem_write, ir_write, pc_write, reg_write,
    input  npc_src, reg_src, alu_op, alu_src, ext_op, reg_dst,
    input  illegal, bus_err, retired, state
  );
endinterface

// File: rtl/mc_ctrl.sv
// Multi-cycle control unit: FETCH/DECODE/EXEC/MEM/WB sequencer with memory
// req/ack handshakes, wait watchdog, illegal-opcode detection and retire counter.
module mc_ctrl #(
  parameter int unsigned WAIT_MAX = 15,
  parameter int unsigned CNT_W    = 32
) (
  input logic       clk,
  input logic       reset,
  mc_ctrl_if.master bus
);

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpOri   = 6'b001101;
  localparam logic [5:0] OpLui   = 6'b001111;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpJ     = 6'b000010;
  localparam logic [5:0] OpJal   = 6'b000011;
  localparam logic [5:0] FnAddu  = 6'b100001;
  localparam logic [5:0] FnSubu  = 6'b100011;
  localparam logic [5:0] FnJr    = 6'b001000;

  localparam int unsigned WaitW = (WAIT_MAX > 0) ? $clog2(WAIT_MAX + 1) : 1;
  localparam logic [WaitW-1:0] WaitMaxC = WaitW'(WAIT_MAX);
  localparam bit WdEn = (WAIT_MAX > 0);

  typedef enum logic [2:0] {
    StFetch  = 3'd0,
    StDecode = 3'd1,
    StExec   = 3'd2,
    StMem    = 3'd3,
    StWb     = 3'd4,
    StHalt   = 3'd7
  } state_e;

  state_e           state_q, state_d;
  logic [WaitW-1:0] wait_q, wait_d;
  logic             bus_err_q, bus_err_d;
  logic [CNT_W-1:0] retired_q;

  logic is_addu, is_subu, is_jr, is_ori, is_lui, is_lw, is_sw, is_beq, is_j, is_jal;
  logic is_illegal, is_jump_class, is_mem;
  logic req_pend, wd_fire, pc_write;

  assign is_addu = (bus.op == OpRtype) && (bus.funct == FnAddu);
  assign is_subu = (bus.op == OpRtype) && (bus.funct == FnSubu);
  assign is_jr   = (bus.op == OpRtype) && (bus.funct == FnJr);
  assign is_ori  = (bus.op == OpOri);
  assign is_lui  = (bus.op == OpLui);
  assign is_lw   = (bus.op == OpLw);
  assign is_sw   = (bus.op == OpSw);
  assign is_beq  = (bus.op == OpBeq);
  assign is_j    = (bus.op == OpJ);
  assign is_jal  = (bus.op == OpJal);
  assign is_illegal = !(is_addu || is_subu || is_jr || is_ori || is_lui ||
                        is_lw || is_sw || is_beq || is_j || is_jal);
  // Instructions that retire straight out of EXEC.
  assign is_jump_class = is_beq || is_j || is_jr || is_illegal;
  assign is_mem        = is_lw || is_sw;

  // Datapath selects: pure decode of op/funct, independent of state.
  always_comb begin
    bus.npc_src = 2'd0;
    bus.reg_src = 2'd0;
    bus.alu_op  = 3'd0;
    bus.alu_src = 1'b0;
    bus.ext_op  = 2'd0;
    bus.reg_dst = 2'd0;
    if (is_addu || is_subu) begin
      bus.reg_dst = 2'd1;
      bus.alu_op  = is_subu ? 3'd1 : 3'd0;
    end else if (is_jr) begin
      bus.npc_src = 2'd3;
    end else if (is_ori) begin
      bus.alu_op  = 3'd2;
      bus.alu_src = 1'b1;
    end else if (is_lui) begin
      bus.alu_src = 1'b1;
      bus.ext_op  = 2'd2;
      bus.reg_src = 2'd2;
    end else if (is_lw || is_sw) begin
      bus.alu_src = 1'b1;
      bus.ext_op  = 2'd1;
      bus.reg_src = is_lw ? 2'd1 : 2'd0;
    end else if (is_beq) begin
      bus.alu_op  = 3'd1;
      bus.ext_op  = 2'd1;
      bus.npc_src = bus.zero ? 2'd1 : 2'd0;
    end else if (is_j) begin
      bus.npc_src = 2'd2;
    end else if (is_jal) begin
      bus.npc_src = 2'd2;
      bus.reg_src = 2'd3;
      bus.reg_dst = 2'd2;
    end
  end

  // Strobes follow the current state; held off while reset is asserted.
  always_comb begin
    bus.imem_req  = reset && (state_q == StFetch);
    bus.ir_write  = bus.imem_req && bus.imem_ack;
    bus.dmem_req  = reset && (state_q == StMem);
    bus.mem_write = bus.dmem_req && is_sw;
    bus.reg_write = reset && (state_q == StWb);
    bus.illegal   = reset && (state_q == StExec) && is_illegal;
    pc_write      = reset && (((state_q == StExec) && is_jump_class) ||
                              (bus.dmem_req && bus.dmem_ack && is_sw) ||
                              (state_q == StWb));
    bus.pc_write  = pc_write;
  end

  // Next state, watchdog counter and sticky bus error.
  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    bus_err_d = bus_err_q;
    req_pend  = ((state_q == StFetch) && !bus.imem_ack) ||
                ((state_q == StMem) && !bus.dmem_ack);
    wd_fire   = WdEn && req_pend && (wait_q == WaitMaxC);
    unique case (state_q)
      StFetch: begin
        if (bus.imem_ack)  state_d = StDecode;
        else if (wd_fire)  state_d = StHalt;
      end
      StDecode: state_d = StExec;
      StExec: begin
        if (is_jump_class) state_d = StFetch;
        else if (is_mem)   state_d = StMem;
        else               state_d = StWb;
      end
      StMem: begin
        if (bus.dmem_ack)  state_d = is_sw ? StFetch : StWb;
        else if (wd_fire)  state_d = StHalt;
      end
      StWb:   state_d = StFetch;
      StHalt: state_d = StHalt;
      default: state_d = StFetch;
    endcase
    if ((state_d == StHalt) && (state_q != StHalt)) bus_err_d = 1'b1;
    // Every state change restarts the wait count; it saturates at WAIT_MAX.
    if (state_d != state_q) begin
      wait_d = '0;
    end else if (req_pend && (wait_q != WaitMaxC)) begin
      wait_d = wait_q + WaitW'(1);
    end
  end

  // State registers; retire count advances on every PC update.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StFetch;
      wait_q    <= '0;
      bus_err_q <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      bus_err_q <= bus_err_d;
      if (pc_write) retired_q <= retired_q + CNT_W'(1);
    end
  end

  assign bus.state   = state_q;
  assign bus.bus_err = bus_err_q;
  assign bus.retired = retired_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Bench for mc_ctrl: decode table, handshake-delay corner cases, randomized
// instruction stream against an instruction-level model, watchdog and reset.
module tb_mc_ctrl;

  logic clk;
  logic reset;

  mc_ctrl_if #(.CNT_W(32)) bus ();

  mc_ctrl #(.WAIT_MAX(3), .CNT_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] npc;
    logic [1:0] rsrc;
    logic [2:0] alu;
    logic       asrc;
    logic [1:0] ext;
    logic [1:0] rdst;
  } sel_t;

  typedef struct {
    string      name;
    logic [5:0] op;
    logic [5:0] funct;
    logic       z;
    int         lat;
    sel_t       exp;
    sel_t       mask;
  } vec_t;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_retired = '0;

  // Instruction codes: 0 illegal, 1 addu, 2 subu, 3 jr, 4 ori, 5 lui, 6 lw,
  // 7 sw, 8 beq, 9 j, 10 jal.
  logic [5:0] code_op [11];
  logic [5:0] code_fn [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic sel_t mk(input int npc, input int rsrc, input int alu, input int asrc,
                              input int ext, input int rdst);
    sel_t s;
    s.npc  = 2'(npc);
    s.rsrc = 2'(rsrc);
    s.alu  = 3'(alu);
    s.asrc = 1'(asrc);
    s.ext  = 2'(ext);
    s.rdst = 2'(rdst);
    return s;
  endfunction

  function automatic int classify(input logic [5:0] o, input logic [5:0] f);
    case (o)
      6'b000000: begin
        if (f == 6'b100001) return 1;
        if (f == 6'b100011) return 2;
        if (f == 6'b001000) return 3;
        return 0;
      end
      6'b001101: return 4;
      6'b001111: return 5;
      6'b100011: return 6;
      6'b101011: return 7;
      6'b000100: return 8;
      6'b000010: return 9;
      6'b000011: return 10;
      default:   return 0;
    endcase
  endfunction

  // Runs one instruction from its FETCH cycle to retirement; entered and left at
  // posedge+1 of a FETCH cycle. Aggregates are checked against the model.
  task automatic run_instr(input string nm, input logic [5:0] o, input logic [5:0] f,
                           input logic z, input int idly, input int ddly,
                           output sel_t sel, output logic [11:0] trace, output int cycles);
    int  code, icnt, dcnt, mw, irw, rw, ill, rw_at_pc, base;
    bit  jumpc, mem, writes, done;
    logic [1:0] exp_npc;
    code = classify(o, f);
    jumpc  = (code == 0) || (code == 3) || (code == 8) || (code == 9);
    mem    = (code == 6) || (code == 7);
    writes = (code == 1) || (code == 2) || (code == 4) || (code == 5) || (code == 6) ||
             (code == 10);
    exp_npc = (code == 3) ? 2'd3 : (code == 8) ? {1'b0, z} :
              ((code == 9) || (code == 10)) ? 2'd2 : 2'd0;
    base = jumpc ? 3 : (code == 6) ? 5 : 4;

    bus.op = o; bus.funct = f; bus.zero = z;
    icnt = 0; dcnt = 0; mw = 0; irw = 0; rw = 0; ill = 0; rw_at_pc = 0;
    cycles = 0; done = 0; trace = '0; sel = '0;
    while (!done && cycles < 40) begin
      bus.imem_ack = (icnt == idly);
      bus.dmem_ack = (dcnt == ddly);
      #1;
      cycles++;
      trace = {trace[8:0], bus.state};
      if (bus.imem_req)  icnt++;
      if (bus.dmem_req)  dcnt++;
      if (bus.mem_write) mw++;
      if (bus.ir_write)  irw++;
      if (bus.reg_write) rw++;
      if (bus.illegal)   ill++;
      if (bus.pc_write) begin
        done = 1;
        rw_at_pc = int'(bus.reg_write);
        sel = {bus.npc_src, bus.reg_src, bus.alu_op, bus.alu_src, bus.ext_op, bus.reg_dst};
      end
      @(posedge clk); #1;
    end
    if (done) exp_retired++;
    chk({nm, "_retire_seen"}, 32'(done), 32'd1);
    chk({nm, "_cycles"}, cycles, base + idly + (mem ? ddly : 0));
    chk({nm, "_imem_req_cycles"}, icnt, idly + 1);
    chk({nm, "_dmem_req_cycles"}, dcnt, mem ? ddly + 1 : 0);
    chk({nm, "_mem_write_cycles"}, mw, (code == 7) ? ddly + 1 : 0);
    chk({nm, "_ir_write"}, irw, 1);
    chk({nm, "_reg_write"}, rw, writes ? 1 : 0);
    chk({nm, "_reg_write_with_pc"}, rw_at_pc, writes ? 1 : 0);
    chk({nm, "_illegal"}, ill, (code == 0) ? 1 : 0);
    chk({nm, "_npc_src"}, 32'(sel.npc), 32'(exp_npc));
    chk({nm, "_state_after"}, 32'(bus.state), 32'd0);
    chk({nm, "_retired"}, bus.retired, exp_retired);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t        tbl [12];
    sel_t        sel;
    logic [11:0] trace;
    int          cyc, code, wd_reqs, wd_cyc;
    logic [5:0]  o, f;
    logic [31:0] ret_hold;

    code_op = '{6'h3f, 6'h00, 6'h00, 6'h00, 6'h0d, 6'h0f, 6'h23, 6'h2b, 6'h04, 6'h02, 6'h03};
    code_fn = '{6'h00, 6'h21, 6'h23, 6'h08, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00};

    tbl[0]  = '{"addu",  6'h00, 6'h21, 1'b0, 4, mk(0,0,0,0,0,1), mk(3,3,7,1,0,3)};
    tbl[1]  = '{"subu",  6'h00, 6'h23, 1'b0, 4, mk(0,0,1,0,0,1), mk(3,3,7,1,0,3)};
    tbl[2]  = '{"jr",    6'h00, 6'h08, 1'b0, 3, mk(3,0,0,0,0,0), mk(3,0,0,0,0,0)};
    tbl[3]  = '{"ori",   6'h0d, 6'h00, 1'b0, 4, mk(0,0,2,1,0,0), mk(3,3,7,1,3,3)};
    tbl[4]  = '{"lui",   6'h0f, 6'h00, 1'b0, 4, mk(0,2,0,0,2,0), mk(3,3,0,0,3,3)};
    tbl[5]  = '{"lw",    6'h23, 6'h00, 1'b0, 5, mk(0,1,0,1,1,0), mk(3,3,7,1,3,3)};
    tbl[6]  = '{"sw",    6'h2b, 6'h00, 1'b0, 4, mk(0,0,0,1,1,0), mk(3,0,7,1,3,0)};
    tbl[7]  = '{"beq_t", 6'h04, 6'h00, 1'b1, 3, mk(1,0,1,0,0,0), mk(3,0,7,1,0,0)};
    tbl[8]  = '{"beq_n", 6'h04, 6'h00, 1'b0, 3, mk(0,0,1,0,0,0), mk(3,0,7,1,0,0)};
    tbl[9]  = '{"j",     6'h02, 6'h00, 1'b0, 3, mk(2,0,0,0,0,0), mk(3,0,0,0,0,0)};
    tbl[10] = '{"jal",   6'h03, 6'h00, 1'b0, 4, mk(2,3,0,0,0,2), mk(3,3,0,0,0,3)};
    tbl[11] = '{"ill",   6'h3f, 6'h00, 1'b0, 3, mk(0,0,0,0,0,0), mk(3,0,0,0,0,0)};

    // Reset held with ack high: everything must stay quiet.
    reset = 1'b0;
    bus.op = 6'h00; bus.funct = 6'h21; bus.zero = 1'b0;
    bus.imem_ack = 1'b1; bus.dmem_ack = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_state", 32'(bus.state), 32'd0);
    chk("rst_retired", bus.retired, 32'd0);
    chk("rst_bus_err", 32'(bus.bus_err), 32'd0);
    chk("rst_imem_req", 32'(bus.imem_req), 32'd0);
    chk("rst_ir_write", 32'(bus.ir_write), 32'd0);
    chk("rst_pc_write", 32'(bus.pc_write), 32'd0);
    reset = 1'b1;

    // addu with zero-wait fetch walks FETCH, DECODE, EXEC, WB.
    run_instr("addu_seq", 6'h00, 6'h21, 1'b0, 0, 0, sel, trace, cyc);
    chk("addu_states", 32'(trace), 32'({3'd0, 3'd1, 3'd2, 3'd4}));

    // Decode table with zero-wait memories.
    for (int i = 0; i < 12; i++) begin
      run_instr(tbl[i].name, tbl[i].op, tbl[i].funct, tbl[i].z, 0, 0, sel, trace, cyc);
      chk({tbl[i].name, "_latency"}, cyc, tbl[i].lat);
      chk({tbl[i].name, "_selects"}, 32'(sel & tbl[i].mask), 32'(tbl[i].exp));
    end

    // lw with data ack 3 cycles late, then both acks at the watchdog limit.
    run_instr("lw_d3", 6'h23, 6'h00, 1'b0, 0, 3, sel, trace, cyc);
    chk("lw_d3_total", cyc, 8);
    run_instr("lw_i3d3", 6'h23, 6'h00, 1'b0, 3, 3, sel, trace, cyc);
    chk("lw_i3d3_bus_err", 32'(bus.bus_err), 32'd0);
    run_instr("sw_i3d3", 6'h2b, 6'h00, 1'b0, 3, 3, sel, trace, cyc);

    // Randomized stream with delays inside the watchdog window.
    for (int n = 0; n < 150; n++) begin
      code = $urandom_range(0, 10);
      if (code == 0) begin
        do begin
          o = 6'($urandom);
          f = 6'($urandom);
        end while (classify(o, f) != 0);
      end else begin
        o = code_op[code];
        f = (o == 6'h00) ? code_fn[code] : 6'($urandom);
      end
      run_instr("rand", o, f, 1'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
                sel, trace, cyc);
    end
    chk("rand_bus_err", 32'(bus.bus_err), 32'd0);

    // Reset during MEM aborts the access.
    bus.op = 6'h23; bus.funct = 6'h00; bus.imem_ack = 1'b1; bus.dmem_ack = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    chk("abort_in_mem", 32'(bus.state), 32'd3);
    reset = 1'b0;
    #1;
    chk("abort_dmem_req", 32'(bus.dmem_req), 32'd0);
    chk("abort_pc_write", 32'(bus.pc_write), 32'd0);
    chk("abort_state", 32'(bus.state), 32'd0);
    chk("abort_retired", bus.retired, 32'd0);
    exp_retired = '0;
    @(posedge clk); #1;
    reset = 1'b1;
    run_instr("after_abort", 6'h0d, 6'h00, 1'b0, 0, 0, sel, trace, cyc);

    // Watchdog: fetch ack never arrives.
    bus.op = 6'h00; bus.funct = 6'h21; bus.imem_ack = 1'b0; bus.dmem_ack = 1'b0;
    ret_hold = bus.retired;
    wd_reqs = 0;
    wd_cyc  = 0;
    while (bus.state != 3'd7 && wd_cyc < 20) begin
      #1;
      if (bus.imem_req) wd_reqs++;
      wd_cyc++;
      @(posedge clk); #1;
    end
    chk("wd_halt_state", 32'(bus.state), 32'd7);
    chk("wd_imem_req_cycles", wd_reqs, 4);
    chk("wd_bus_err", 32'(bus.bus_err), 32'd1);
    chk("wd_imem_req_off", 32'(bus.imem_req), 32'd0);
    bus.imem_ack = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
    end
    chk("wd_still_halt", 32'(bus.state), 32'd7);
    chk("wd_retired_frozen", bus.retired, ret_hold);
    chk("wd_retired_value", bus.retired, exp_retired);
    reset = 1'b0;
    #1;
    chk("wd_rst_state", 32'(bus.state), 32'd0);
    chk("wd_rst_bus_err", 32'(bus.bus_err), 32'd0);
    chk("wd_rst_retired", bus.retired, 32'd0);
    exp_retired = '0;
    @(posedge clk); #1;
    reset = 1'b1;
    run_instr("after_wd", 6'h03, 6'h00, 1'b0, 1, 0, sel, trace, cyc);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
